nlprg_period_checker: RTL and testbench
=======================================

Name: nlprg_period_checker

Overview:
- Hardware sequence monitor that sits directly downstream of an nlprg PRNG and consumes its output word every enabled cycle.
- Records the first sample as the seed and tracks which of the 2^N states have been visited.
- Reports the measured period, whether the sequence is full-period, and the first non-seed repeat if one occurs.
- Replaces log-file post-processing with an on-chip pass/fail result usable in simulation and on FPGA.

Parameters:
- N, 4, width of the PRNG word; the state space is 2^N.

Ports:
- ck  input  1  clock; all logic on posedge ck.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin or restart a check.
- en  input  1  d is a valid PRNG sample this cycle.
- d  input  N  PRNG output word (nlprg o).
- busy  output  1  check in progress (ARM or RUN).
- done  output  1  result valid; level, held in DONE.
- pass  output  1  sequence closed on the seed after exactly 2^N distinct states with no repeat.
- dup_err  output  1  a non-seed state repeated before the sequence returned to the seed.
- dup_val  output  N  value of the first repeated state.
- seed  output  N  first sample captured in ARM.
- period  output  N+1  distinct states seen when the check ended.

Behaviour:
- All outputs are registered.
- Reset:
  - On rst=1 at posedge ck: state=IDLE.
  - busy, done, pass and dup_err are 0; dup_val, seed and period are 0.
  - The visited bitmap (2^N bits) is cleared and the internal count is 0.
  - rst has priority over every other input, including mid-check.
- FSM states: IDLE, ARM, RUN, DONE.
- start (any state, rst=0):
  - Next state is ARM.
  - Bitmap cleared; count=0; done, pass and dup_err forced to 0.
  - start overrides en in the same cycle: that sample is discarded.
  - start during RUN aborts and restarts the check.
- IDLE: en ignored; waits for start.
- ARM, en=1:
  - seed<=d; visited[d]<=1; count<=1; next state RUN.
  - en=0: stay in ARM.
- RUN, en=1, checks in priority order:
  - d==seed: period<=count; pass<=(count==2^N); dup_err<=0; next state DONE.
  - visited[d]==1: dup_err<=1; dup_val<=d; period<=count; pass<=0; next state DONE.
  - Otherwise: visited[d]<=1; count<=count+1; stay in RUN.
- RUN, en=0: no change; bubbles are not counted.
- No timeout is needed. Once count reaches 2^N, every state is visited, so the next enabled sample must take the seed branch or the duplicate branch. count never exceeds 2^N, which fits in N+1 bits.
- Timing:
  - done, pass, dup_err and period update on the posedge that samples the closing d; they are visible the following cycle.
  - busy drops on that same edge.
- DONE: outputs held; en ignored; leaves only on start or rst.
- busy = 1 exactly in ARM and RUN.
- dup_val is updated only on a duplicate and holds its last value otherwise.
- A self-loop (second sample == seed) gives period=1, pass=0 unless N=0. N=0 is unsupported; N ≥ 1.

Test Plan:
- Full period:
  - Stimulus: rst, start, then en=1 with d=0,1,2,…,15,0 (N=4).
  - Required: done=1, pass=1, period=16, dup_err=0, seed=0.
- Short cycle:
  - Stimulus: start, then d=3,7,3.
  - Required: done=1, pass=0, period=2, dup_err=0, seed=3.
- Duplicate:
  - Stimulus: start, then d=1,2,5,2.
  - Required: done=1, dup_err=1, dup_val=2, period=3, pass=0.
- Bubbles and ignore rules:
  - Stimulus: full-period sequence of test 1 with en toggling 1,0,1,0…, and samples also applied while in IDLE/DONE.
  - Required: same result as test 1; samples in IDLE and DONE have no effect.
- Restart and reset:
  - Stimulus: start, d=4,9; then start+en with d=6 in the same cycle; then d=4,4.
  - Required: d=6 is discarded, seed=4, period=1, pass=0.
  - Then assert rst during RUN: all outputs 0 on the next cycle, state IDLE.
- Integration with nlprg4:
  - Stimulus: drive from nlprg4 o with en=1 and start released one cycle after rst.
  - Required: done=1, pass=1, period=16.

Source files
------------

// File: rtl/nlprg_period_checker.sv
// Period checker that sits downstream of an nlprg PRNG. It takes the first
// enabled sample as the seed and marks each state it sees in a visited bitmap.
// The check closes when the sequence returns to the seed, or when a non-seed
// state is seen a second time. It then reports the measured period, a
// full-period pass flag, and the first repeated value.
//
// Handshake: there is no back-pressure. d is consumed on every posedge ck
// with en=1 while the FSM is in ARM or RUN, and is ignored in IDLE and DONE.
// start is a single-cycle request. It wins over en in the same cycle, and
// rst wins over everything.
module nlprg_period_checker #(
   parameter int N = 4
) (
   input  logic         ck,
   input  logic         rst,
   input  logic         start,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         dup_err,
   output logic [N-1:0] dup_val,
   output logic [N-1:0] seed,
   output logic [N:0]   period,
   output logic [1:0]   dbg_state
);

   localparam int unsigned DEPTH    = 1 << N;
   localparam logic [N:0]  FULL_CNT = DEPTH[N:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] visited_q, visited_d;
   logic [N:0]       count_q, count_d;
   logic [N-1:0]     seed_q, seed_d;
   logic [N-1:0]     dup_val_q, dup_val_d;
   logic [N:0]       period_q, period_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             dup_err_q, dup_err_d;
   logic             busy_q, busy_d;

   // Next-state and result computation; every register holds by default.
   always_comb begin
      state_d   = state_q;
      visited_d = visited_q;
      count_d   = count_q;
      seed_d    = seed_q;
      dup_val_d = dup_val_q;
      period_d  = period_q;
      done_d    = done_q;
      pass_d    = pass_q;
      dup_err_d = dup_err_q;

      if (start) begin
         // Begin or restart. Any sample presented with start is dropped.
         state_d   = S_ARM;
         visited_d = '0;
         count_d   = '0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         dup_err_d = 1'b0;
      end else begin
         case (state_q)
            S_ARM: begin
               if (en) begin
                  seed_d       = d;
                  visited_d[d] = 1'b1;
                  count_d      = {{N{1'b0}}, 1'b1};
                  state_d      = S_RUN;
               end
            end
            S_RUN: begin
               if (en) begin
                  if (d == seed_q) begin
                     // The sequence closed on the seed.
                     period_d  = count_q;
                     pass_d    = (count_q == FULL_CNT);
                     dup_err_d = 1'b0;
                     done_d    = 1'b1;
                     state_d   = S_DONE;
                  end else if (visited_q[d]) begin
                     // The sequence fell into a cycle that does not include the seed.
                     dup_err_d = 1'b1;
                     dup_val_d = d;
                     period_d  = count_q;
                     pass_d    = 1'b0;
                     done_d    = 1'b1;
                     state_d   = S_DONE;
                  end else begin
                     visited_d[d] = 1'b1;
                     count_d      = count_q + 1'b1;
                  end
               end
            end
            default: begin
               // IDLE and DONE ignore samples and wait for start.
            end
         endcase
      end

      // busy is registered from the next state, so it falls on the closing edge.
      busy_d = (state_d == S_ARM) || (state_d == S_RUN);
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge ck) begin
      if (rst) begin
         state_q   <= S_IDLE;
         visited_q <= '0;
         count_q   <= '0;
         seed_q    <= '0;
         dup_val_q <= '0;
         period_q  <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         dup_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         visited_q <= visited_d;
         count_q   <= count_d;
         seed_q    <= seed_d;
         dup_val_q <= dup_val_d;
         period_q  <= period_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         dup_err_q <= dup_err_d;
         busy_q    <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign dup_err   = dup_err_q;
   assign dup_val   = dup_val_q;
   assign seed      = seed_q;
   assign period    = period_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_nlprg_period_checker.sv
// Bench for nlprg_period_checker: directed scenarios, randomized sequences
// with bubbles, and a full-period generator stand-in for the nlprg source.
module tb_nlprg_period_checker;

   localparam int N = 4;
   localparam int DEPTH = 1 << N;

   logic         ck = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         en = 1'b0;
   logic [N-1:0] d = '0;
   logic         busy, done, pass, dup_err;
   logic [N-1:0] dup_val, seed;
   logic [N:0]   period;
   logic [1:0]   dbg_state;

   int checks = 0;
   int failures = 0;
   int exp_dup_val = 0;

   nlprg_period_checker #(.N(N)) dut (
      .ck(ck), .rst(rst), .start(start), .en(en), .d(d),
      .busy(busy), .done(done), .pass(pass), .dup_err(dup_err),
      .dup_val(dup_val), .seed(seed), .period(period), .dbg_state(dbg_state)
   );

   // Clock.
   always #5 ck = ~ck;

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge ck);
      #1;
   endtask

   // Reference model. Walk the enabled samples that follow start, using a set
   // of the states seen so far, and derive the outcome of the check.
   function automatic void ref_model(input int smp[$], output int e_pass, output int e_dup,
                                     output int e_period, output int e_seed, output int e_closed);
      bit seen[int];
      e_pass = 0; e_dup = 0; e_period = 0; e_closed = 0;
      e_seed = smp[0];
      seen[smp[0]] = 1'b1;
      for (int i = 1; i < smp.size(); i++) begin
         if (smp[i] == e_seed) begin
            e_period = seen.num(); e_pass = (e_period == DEPTH) ? 1 : 0; e_closed = 1;
            break;
         end else if (seen.exists(smp[i])) begin
            e_dup = 1; exp_dup_val = smp[i]; e_period = seen.num(); e_closed = 1;
            break;
         end
         seen[smp[i]] = 1'b1;
      end
   endfunction

   // Present samples with en=1, optionally putting random en=0 bubbles between them.
   task automatic run_seq(input int smp[$], input bit bubbles);
      for (int i = 0; i < smp.size(); i++) begin
         if (bubbles && ($urandom_range(0, 1) == 1)) begin
            en = 1'b0; d = N'($urandom_range(0, DEPTH - 1)); cyc();
         end
         en = 1'b1; d = N'(smp[i]); cyc();
      end
      en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; en = 1'b0; cyc(); start = 1'b0;
   endtask

   // Wait for done, but give up after a fixed number of cycles.
   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin cyc(); n++; end
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL %s done_timeout got=%0b exp=1", name, done); end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; en = 1'b1; d = 4'd5; cyc(); cyc();
      rst = 1'b0; en = 1'b0;
      checks++; if ({busy, done, pass, dup_err} !== 4'b0) begin failures++; $display("FAIL reset flags got=%b exp=0000", {busy, done, pass, dup_err}); end
      checks++; if ({dup_val, seed, period} !== '0) begin failures++; $display("FAIL reset values got=%h exp=0", {dup_val, seed, period}); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset state got=%0d exp=0", dbg_state); end
      exp_dup_val = 0;
   endtask

   task automatic check_result(input string name, input int smp[$]);
      int e_pass, e_dup, e_period, e_seed, e_closed;
      ref_model(smp, e_pass, e_dup, e_period, e_seed, e_closed);
      wait_done(name, 4);
      checks++; if (pass !== e_pass[0]) begin failures++; $display("FAIL %s pass got=%0b exp=%0d", name, pass, e_pass); end
      checks++; if (dup_err !== e_dup[0]) begin failures++; $display("FAIL %s dup_err got=%0b exp=%0d", name, dup_err, e_dup); end
      checks++; if (period !== (N+1)'(e_period)) begin failures++; $display("FAIL %s period got=%0d exp=%0d", name, period, e_period); end
      checks++; if (seed !== N'(e_seed)) begin failures++; $display("FAIL %s seed got=%0d exp=%0d", name, seed, e_seed); end
      checks++; if (dup_val !== N'(exp_dup_val)) begin failures++; $display("FAIL %s dup_val got=%0d exp=%0d", name, dup_val, exp_dup_val); end
      checks++; if (busy !== 1'b0 || dbg_state !== 2'd3) begin failures++; $display("FAIL %s busy_state got=%0b/%0d exp=0/3", name, busy, dbg_state); end
   endtask

   task automatic test_full_period();
      int s[$];
      for (int i = 0; i < DEPTH; i++) s.push_back(i);
      s.push_back(0);
      pulse_start();
      checks++; if (busy !== 1'b1 || dbg_state !== 2'd1 || done !== 1'b0) begin failures++; $display("FAIL full arm got busy=%0b state=%0d done=%0b exp=1/1/0", busy, dbg_state, done); end
      run_seq(s, 1'b0);
      check_result("full", s);
      checks++; if (pass !== 1'b1 || period !== 5'd16) begin failures++; $display("FAIL full fixed got pass=%0b period=%0d exp=1/16", pass, period); end
   endtask

   task automatic test_short_cycle();
      int s[$] = '{3, 7, 3};
      pulse_start();
      run_seq(s, 1'b0);
      check_result("short", s);
      checks++; if (period !== 5'd2 || seed !== 4'd3) begin failures++; $display("FAIL short fixed got period=%0d seed=%0d exp=2/3", period, seed); end
   endtask

   task automatic test_duplicate();
      int s[$] = '{1, 2, 5, 2};
      pulse_start();
      run_seq(s, 1'b0);
      check_result("dup", s);
      checks++; if (dup_err !== 1'b1 || dup_val !== 4'd2 || period !== 5'd3) begin failures++; $display("FAIL dup fixed got err=%0b val=%0d period=%0d exp=1/2/3", dup_err, dup_val, period); end
   endtask

   task automatic test_bubbles();
      int s[$];
      logic [N:0] p_hold;
      for (int i = 0; i < DEPTH; i++) s.push_back(i);
      s.push_back(0);
      // Samples presented in IDLE must leave the block idle.
      rst = 1'b1; cyc(); rst = 1'b0;
      for (int i = 0; i < 5; i++) begin en = 1'b1; d = N'($urandom_range(0, DEPTH - 1)); cyc(); end
      en = 1'b0;
      checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || seed !== 4'd0) begin failures++; $display("FAIL idle_ignore got state=%0d busy=%0b seed=%0d exp=0/0/0", dbg_state, busy, seed); end
      exp_dup_val = 0;
      pulse_start();
      for (int i = 0; i < s.size(); i++) begin
         en = 1'b1; d = N'(s[i]); cyc();
         en = 1'b0; d = N'($urandom_range(0, DEPTH - 1)); if (i < s.size() - 1) cyc();
      end
      check_result("bubbles", s);
      // Samples presented in DONE must not change the result.
      p_hold = period;
      for (int i = 0; i < 6; i++) begin en = 1'b1; d = N'($urandom_range(0, DEPTH - 1)); cyc(); end
      en = 1'b0;
      checks++; if (done !== 1'b1 || pass !== 1'b1 || period !== p_hold || dbg_state !== 2'd3) begin failures++; $display("FAIL done_ignore got done=%0b pass=%0b period=%0d state=%0d exp=1/1/%0d/3", done, pass, period, dbg_state, p_hold); end
   endtask

   task automatic test_restart_reset();
      int a[$] = '{4, 9};
      int b[$] = '{4, 4};
      pulse_start();
      run_seq(a, 1'b0);
      start = 1'b1; en = 1'b1; d = 4'd6; cyc(); start = 1'b0; en = 1'b0;
      checks++; if (dbg_state !== 2'd1 || done !== 1'b0) begin failures++; $display("FAIL restart arm got state=%0d done=%0b exp=1/0", dbg_state, done); end
      run_seq(b, 1'b0);
      check_result("restart", b);
      checks++; if (seed !== 4'd4 || period !== 5'd1 || pass !== 1'b0) begin failures++; $display("FAIL restart fixed got seed=%0d period=%0d pass=%0b exp=4/1/0", seed, period, pass); end
      // Reset in the middle of a check.
      pulse_start();
      run_seq('{1, 2, 3}, 1'b0);
      rst = 1'b1; cyc(); rst = 1'b0;
      checks++; if ({busy, done, pass, dup_err, dup_val, seed, period} !== '0 || dbg_state !== 2'd0) begin failures++; $display("FAIL rst_mid got outs=%h state=%0d exp=0/0", {busy, done, pass, dup_err, dup_val, seed, period}, dbg_state); end
      exp_dup_val = 0;
   endtask

   task automatic test_random();
      int perm[DEPTH];
      int s[$];
      int len, tmp, j;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < DEPTH; i++) perm[i] = i;
         for (int i = DEPTH - 1; i > 0; i--) begin
            j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         len = $urandom_range(1, DEPTH);
         s.delete();
         for (int i = 0; i < len; i++) s.push_back(perm[i]);
         if (len == 1 || $urandom_range(0, 1) == 0) s.push_back(perm[0]);
         else s.push_back(perm[$urandom_range(1, len - 1)]);
         pulse_start();
         run_seq(s, 1'b1);
         check_result($sformatf("rand%0d", it), s);
      end
   endtask

   // Full-period source standing in for nlprg4: a fixed random permutation replayed cyclically.
   task automatic test_nlprg();
      int perm[DEPTH];
      int tmp, j, idx;
      for (int i = 0; i < DEPTH; i++) perm[i] = i;
      for (int i = DEPTH - 1; i > 0; i--) begin
         j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      idx = 0;
      en = 1'b1; rst = 1'b1; start = 1'b1;
      for (int i = 0; i < 2; i++) begin d = N'(perm[idx % DEPTH]); idx++; cyc(); end
      rst = 1'b0;
      d = N'(perm[idx % DEPTH]); idx++; cyc();
      start = 1'b0;
      for (int i = 0; i < 3 * DEPTH && done !== 1'b1; i++) begin d = N'(perm[idx % DEPTH]); idx++; cyc(); end
      en = 1'b0;
      checks++; if (done !== 1'b1 || pass !== 1'b1 || period !== 5'd16 || dup_err !== 1'b0) begin failures++; $display("FAIL nlprg got done=%0b pass=%0b period=%0d dup=%0b exp=1/1/16/0", done, pass, period, dup_err); end
   endtask

   initial begin
      test_reset();
      test_full_period();
      test_short_cycle();
      test_duplicate();
      test_bubbles();
      test_restart_reset();
      test_random();
      test_nlprg();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
